load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's memory stage and the word-addressed data RAM.
- The data RAM has a registered read address (data valid the cycle after the address edge) and no byte enables.
- Converts byte-addressed RV32 loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses:
  - loads: lane extraction plus sign/zero extension;
  - sub-word stores: read-modify-write;
  - misaligned or illegal accesses: flagged as errors.

Parameters:
- ADDR_WIDTH, 8: RAM word-address width (RAM depth 2**ADDR_WIDTH words of 32 bits).
- REQ_ADDR_WIDTH, 32: width of the core's byte address.

Ports:
- Clock and reset (one clock; reset is asynchronous and active-low):
  - clk  input  1  clock, all state updates on rising edge.
  - rst_n  input  1  asynchronous active-low reset.
- Core request:
  - req_valid  input  1  request present.
  - req_ready  output  1  unit idle and accepting requests.
  - req_we  input  1  1 = store, 0 = load.
  - req_funct3  input  3  RV32 funct3 size/sign code.
  - req_addr  input  REQ_ADDR_WIDTH  byte address.
  - req_wdata  input  32  store data (low bits used for SB/SH).
- Core response:
  - rsp_valid  output  1  one-cycle completion pulse.
  - rsp_err  output  1  access rejected (qualified by rsp_valid).
  - rsp_rdata  output  32  extended load data (0 for stores/errors).
- Data RAM side:
  - mem_addr  output  ADDR_WIDTH  RAM word address.
  - mem_data_in  output  32  RAM write data.
  - mem_we  output  1  RAM write enable.
  - mem_data_out  input  32  RAM read data.

Behaviour:
- States: IDLE, LOAD_CAP, RMW_MERGE. req_ready = (state == IDLE). Requests are only sampled in IDLE; the core holds its request while req_ready=0.
- Word address = req_addr[ADDR_WIDTH+1:2]. Lane = req_addr[1:0].
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- IDLE, illegal or misaligned request: no RAM access (mem_we=0), stay in IDLE. Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
- IDLE, load: mem_addr = word address, mem_we=0. Latch lane and funct3. Go to LOAD_CAP.
- LOAD_CAP:
  - Select byte [8*lane+7:8*lane] or halfword [16*addr[1]+15:16*addr[1]] from mem_data_out.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes the word through.
  - Register the result into rsp_rdata. Go to IDLE.
  - rsp_valid=1 the next cycle. Load latency: acceptance edge + 2 cycles.
- IDLE, SW: mem_addr = word address, mem_data_in = req_wdata, mem_we=1 in the same cycle. rsp_valid next cycle. Stay in IDLE.
- IDLE, SB/SH: drive a read of the word address. Latch address, lane, size and data. Go to RMW_MERGE.
- RMW_MERGE:
  - mem_addr = latched address, mem_we=1.
  - mem_data_in = mem_data_out with only the addressed byte/halfword replaced by req_wdata[7:0] / [15:0].
  - Go to IDLE. rsp_valid next cycle.
- Memory-side outputs are combinational from state, latched fields and request. They are all 0 whenever state is IDLE and req_valid=0.
- mem_we is never asserted for an errored access.
- rsp_valid is a registered single-cycle pulse. rsp_err and rsp_rdata hold their value until the next response.
- Reset (rst_n low):
  - state=IDLE; rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_we, mem_addr and mem_data_in are forced to 0 while rst_n is low.
  - An in-flight RMW write is dropped with no RAM write; an in-flight load produces no response.
- Back-to-back: a new request may be accepted in the same cycle that rsp_valid pulses for the previous one.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- Defined: any nonzero req_addr bit above bit ADDR_WIDTH+1 is treated as an error. No RAM access; rsp_err=1 with the same timing as a misaligned access.
- Undefined: upper address bits are ignored and the address aliases into the RAM.

Test Plan:
- SW addr 0x10, data 0xDEADBEEF; then LW 0x10 -> mem_we pulses once at word 4; LW rsp_valid 2 cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Word 4 = 0x11223344, SB addr 0x12 data 0xAB -> req_ready low 1 cycle, RAM word 4 = 0x11AB3344, rsp_valid 2 cycles after acceptance.
- Word 4 = 0x8000F0FF: LB 0x10 -> 0xFFFFFFFF; LBU 0x10 -> 0x000000FF; LH 0x12 -> 0xFFFF8000; LHU 0x12 -> 0x00008000.
- LW 0x11, SH 0x13, funct3=011 -> each gives rsp_err=1, rsp_rdata=0, mem_we never asserted, RAM unchanged.
- SH 0x16 data 0xCAFE, rst_n pulsed low during RMW_MERGE -> no RAM write, req_ready=1 after reset, no rsp_valid.
- With LSU_BOUNDS_CHECK_EN, ADDR_WIDTH=8, LW 0x400 -> rsp_err=1. Without it -> reads word 0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core-side request/response bundle of the load/store unit.
interface load_store_unit_if #(
  parameter int REQ_ADDR_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [2:0]                req_funct3;
  logic [REQ_ADDR_WIDTH-1:0] req_addr;
  logic [31:0]               req_wdata;
  logic                      rsp_valid;
  logic                      rsp_err;
  logic [31:0]               rsp_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32 byte-addressed load/store to word RAM with read-modify-write.
// Optional LSU_BOUNDS_CHECK_EN: nonzero address bits above the RAM range flag an error.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 8,
  parameter int REQ_ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  load_store_unit_if.slave      core,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data_in,
  output logic                  mem_we,
  input  logic [31:0]           mem_data_out
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_CAP  = 2'd1,
    RMW_MERGE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [1:0]            lat_lane;
  logic [2:0]            lat_funct3;
  logic [15:0]           lat_wdata;

  logic                  legal;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;
  logic                  is_sw;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] req_word;
  logic [31:0]           load_word;
  logic [31:0]           rmw_word;

  assign req_word       = core.req_addr[ADDR_WIDTH+1:2];
  assign is_sw          = core.req_we && (core.req_funct3 == 3'b010);
  assign accept         = (state_q == IDLE) && core.req_valid;
  assign core.req_ready = (state_q == IDLE);

`ifdef LSU_BOUNDS_CHECK_EN
  assign out_of_range = |core.req_addr[REQ_ADDR_WIDTH-1:ADDR_WIDTH+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |core.req_addr[REQ_ADDR_WIDTH-1:ADDR_WIDTH+2];
  assign out_of_range   = 1'b0;
`endif

  always_comb begin
    legal = 1'b0;
    case (core.req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !core.req_we;
      default:                legal = 1'b0;
    endcase
    misaligned = ((core.req_funct3[1:0] == 2'b01) && core.req_addr[0]) ||
                 ((core.req_funct3[1:0] == 2'b10) && (core.req_addr[1:0] != 2'b00));
    req_err = !legal || misaligned || out_of_range;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (core.req_valid && !req_err) begin
          if (!core.req_we)  state_d = LOAD_CAP;
          else if (!is_sw)   state_d = RMW_MERGE;
        end
      end
      LOAD_CAP:  state_d = IDLE;
      RMW_MERGE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Lane extraction from the word returned for the latched load.
  always_comb begin
    load_word = mem_data_out;
    case (lat_funct3)
      3'b000: load_word = {{24{mem_data_out[{lat_lane, 3'b111}]}},
                           mem_data_out[{lat_lane, 3'b000} +: 8]};
      3'b100: load_word = {24'h0, mem_data_out[{lat_lane, 3'b000} +: 8]};
      3'b001: load_word = {{16{mem_data_out[{lat_lane[1], 4'b1111}]}},
                           mem_data_out[{lat_lane[1], 4'b0000} +: 16]};
      3'b101: load_word = {16'h0, mem_data_out[{lat_lane[1], 4'b0000} +: 16]};
      default: load_word = mem_data_out;
    endcase
  end

  always_comb begin
    rmw_word = mem_data_out;
    if (lat_funct3[0] == 1'b0) rmw_word[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
    else                       rmw_word[{lat_lane[1], 4'b0000} +: 16] = lat_wdata;
  end

  // RAM port is combinational so SW and the RMW write land in the same cycle they are decided.
  always_comb begin
    mem_addr    = '0;
    mem_data_in = '0;
    mem_we      = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (core.req_valid && !req_err) begin
            mem_addr = req_word;
            if (is_sw) begin
              mem_data_in = core.req_wdata;
              mem_we      = 1'b1;
            end
          end
        end
        LOAD_CAP: mem_addr = lat_addr;
        RMW_MERGE: begin
          mem_addr    = lat_addr;
          mem_data_in = rmw_word;
          mem_we      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr       <= '0;
      lat_lane       <= '0;
      lat_funct3     <= '0;
      lat_wdata      <= '0;
      core.rsp_valid <= 1'b0;
      core.rsp_err   <= 1'b0;
      core.rsp_rdata <= '0;
    end else begin
      core.rsp_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            lat_addr   <= req_word;
            lat_lane   <= core.req_addr[1:0];
            lat_funct3 <= core.req_funct3;
            lat_wdata  <= core.req_wdata[15:0];
            if (req_err || is_sw) begin
              core.rsp_valid <= 1'b1;
              core.rsp_err   <= req_err;
              core.rsp_rdata <= '0;
            end
          end
        end
        LOAD_CAP: begin
          core.rsp_valid <= 1'b1;
          core.rsp_err   <= 1'b0;
          core.rsp_rdata <= load_word;
        end
        RMW_MERGE: begin
          core.rsp_valid <= 1'b1;
          core.rsp_err   <= 1'b0;
          core.rsp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a byte-array model.
module tb_load_store_unit;
  localparam int AW     = 8;
  localparam int RAW    = 32;
  localparam int NWORDS = 1 << AW;
  localparam int NBYTES = 4 * NWORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data_in;
  logic          mem_we;
  logic [31:0]   mem_data_out;
  logic          ram_clear;
  logic [31:0]   ram [NWORDS];
  logic [7:0]    ref_bytes [NBYTES];

  int checks = 0;
  int errors = 0;

  load_store_unit_if #(.REQ_ADDR_WIDTH(RAW)) core ();

  load_store_unit #(.ADDR_WIDTH(AW), .REQ_ADDR_WIDTH(RAW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core         (core),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < NWORDS; i++) ram[i] <= '0;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_data_in;
    end
    mem_data_out <= ram[mem_addr];
  end

  // Reference: little-endian byte array, accesses assembled byte by byte.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic err, output logic [31:0] rdata);
    bit          legal;
    int          size;
    int          base;
    logic [31:0] val;
    logic [31:0] mask;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    err   = !legal || ((addr % size) != 0);
`ifdef LSU_BOUNDS_CHECK_EN
    if (addr >= NBYTES) err = 1'b1;
`endif
    rdata = '0;
    if (!err) begin
      base = int'(addr % NBYTES);
      if (we) begin
        for (int k = 0; k < size; k++) ref_bytes[base + k] = wd[8*k +: 8];
      end else begin
        val = '0;
        for (int k = 0; k < size; k++) val = val | (32'(ref_bytes[base + k]) << (8 * k));
        if (size < 4) begin
          mask = (32'h1 << (8 * size)) - 32'h1;
          if (!f3[2] && val[8*size-1]) val = val | ~mask;
        end
        rdata = val;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] got_rdata, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat, exp_we, lat, we_cnt, busy_cnt;
    model_access(we, f3, addr, wd, exp_err, exp_rdata);
    exp_lat = (exp_err || (we && f3 == 3'b010)) ? 1 : 2;
    exp_we  = (we && !exp_err) ? 1 : 0;
    @(posedge clk); #1;
    core.req_valid  = 1'b1;
    core.req_we     = we;
    core.req_funct3 = f3;
    core.req_addr   = addr;
    core.req_wdata  = wd;
    we_cnt = 0; busy_cnt = 0; lat = 0;
    @(negedge clk);
    if (mem_we === 1'b1) we_cnt++;
    @(posedge clk); #1;
    core.req_valid = 1'b0;
    core.req_addr  = '0;
    core.req_wdata = '0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (mem_we === 1'b1) we_cnt++;
      if (core.rsp_valid === 1'b1) lat = i;
      else if (core.req_ready !== 1'b1) busy_cnt++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency we=%0b f3=%0d addr=%h: got %0d cycles, expected %0d", we, f3, addr, lat, exp_lat);
    end
    checks++;
    if (core.rsp_err !== exp_err) begin
      errors++;
      $display("FAIL rsp_err we=%0b f3=%0d addr=%h: got %b, expected %b", we, f3, addr, core.rsp_err, exp_err);
    end
    checks++;
    if (core.rsp_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL rsp_rdata we=%0b f3=%0d addr=%h: got %h, expected %h", we, f3, addr, core.rsp_rdata, exp_rdata);
    end
    checks++;
    if (we_cnt != exp_we) begin
      errors++;
      $display("FAIL mem_we_pulses we=%0b f3=%0d addr=%h: got %0d, expected %0d", we, f3, addr, we_cnt, exp_we);
    end
    checks++;
    if (busy_cnt != exp_lat - 1) begin
      errors++;
      $display("FAIL busy_cycles we=%0b f3=%0d addr=%h: got %0d, expected %0d", we, f3, addr, busy_cnt, exp_lat - 1);
    end
    got_rdata = core.rsp_rdata;
    got_err   = core.rsp_err;
  endtask

  task automatic check_ram(input string tag);
    int          bad;
    int          first;
    logic [31:0] exp_w;
    bad = 0; first = -1;
    for (int w = 0; w < NWORDS; w++) begin
      exp_w = {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
      if (ram[w] !== exp_w) begin
        bad++;
        if (first < 0) first = w;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ram_contents %s: %0d words differ, first word %0d got %h expected %h", tag, bad,
               first, ram[first], {ref_bytes[4*first+3], ref_bytes[4*first+2], ref_bytes[4*first+1], ref_bytes[4*first]});
    end
  endtask

  task automatic test_reset();
    core.req_valid  = 1'b1;
    core.req_we     = 1'b1;
    core.req_funct3 = 3'b010;
    core.req_addr   = 32'h10;
    core.req_wdata  = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (core.req_ready !== 1'b1 || core.rsp_valid !== 1'b0 || core.rsp_err !== 1'b0 || core.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp: ready=%b valid=%b err=%b rdata=%h, expected 1 0 0 0", core.req_ready, core.rsp_valid, core.rsp_err, core.rsp_rdata);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_data_in !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: we=%b addr=%h din=%h, expected all 0", mem_we, mem_addr, mem_data_in);
    end
    core.req_valid = 1'b0;
    core.req_addr  = '0;
    core.req_wdata = '0;
    @(posedge clk); #1;
    ram_clear = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] d;
    logic        e;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, d, e);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, d, e);
    checks++;
    if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin
      errors++;
      $display("FAIL sw_lw: got %h err=%b, expected deadbeef err=0", d, e);
    end
  endtask

  task automatic test_sub_word_store();
    logic [31:0] d;
    logic        e;
    do_req(1'b1, 3'b010, 32'h10, 32'h1122_3344, d, e);
    do_req(1'b1, 3'b000, 32'h12, 32'hFFFF_FFAB, d, e);
    checks++;
    if (ram[4] !== 32'h11AB_3344) begin
      errors++;
      $display("FAIL sb_merge: word4 got %h, expected 11ab3344", ram[4]);
    end
    do_req(1'b1, 3'b001, 32'h12, 32'h1234_CAFE, d, e);
    checks++;
    if (ram[4] !== 32'hCAFE_3344) begin
      errors++;
      $display("FAIL sh_merge: word4 got %h, expected cafe3344", ram[4]);
    end
  endtask

  task automatic test_load_extend();
    logic [31:0] d;
    logic        e;
    logic [2:0]  f3s  [4];
    logic [31:0] adrs [4];
    logic [31:0] exps [4];
    f3s  = '{3'b000, 3'b100, 3'b001, 3'b101};
    adrs = '{32'h10, 32'h10, 32'h12, 32'h12};
    exps = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_8000, 32'h0000_8000};
    do_req(1'b1, 3'b010, 32'h10, 32'h8000_F0FF, d, e);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3s[i], adrs[i], 32'h0, d, e);
      checks++;
      if (d !== exps[i]) begin
        errors++;
        $display("FAIL load_extend f3=%0d addr=%h: got %h, expected %h", f3s[i], adrs[i], d, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic        e;
    do_req(1'b0, 3'b010, 32'h11, 32'h0, d, e);
    do_req(1'b1, 3'b001, 32'h13, 32'h5555, d, e);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, d, e);
    do_req(1'b1, 3'b011, 32'h10, 32'h7777_7777, d, e);
    do_req(1'b1, 3'b100, 32'h10, 32'h7777_7777, d, e);
    checks++;
    if (d !== 32'h0 || e !== 1'b1 || ram[4] !== 32'h8000_F0FF) begin
      errors++;
      $display("FAIL illegal_store: rdata=%h err=%b word4=%h, expected 0 1 8000f0ff", d, e, ram[4]);
    end
  endtask

  task automatic test_bounds();
    logic [31:0] d;
    logic        e;
    do_req(1'b1, 3'b010, 32'h0, 32'h0BAD_CAFE, d, e);
    do_req(1'b0, 3'b010, 32'h400, 32'h0, d, e);
    checks++;
`ifdef LSU_BOUNDS_CHECK_EN
    if (e !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL bounds_lw_400: err=%b rdata=%h, expected err=1 rdata=0", e, d);
    end
`else
    if (e !== 1'b0 || d !== 32'h0BAD_CAFE) begin
      errors++;
      $display("FAIL alias_lw_400: err=%b rdata=%h, expected err=0 rdata=0badcafe", e, d);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic        e;
    logic [31:0] d;
    model_access(1'b1, 3'b010, 32'h20, 32'h0BAD_F00D, e, d);
    @(posedge clk); #1;
    core.req_valid  = 1'b1;
    core.req_we     = 1'b1;
    core.req_funct3 = 3'b010;
    core.req_addr   = 32'h20;
    core.req_wdata  = 32'h0BAD_F00D;
    @(posedge clk); #1;
    core.req_we     = 1'b0;
    core.req_wdata  = '0;
    @(negedge clk);
    checks++;
    if (core.rsp_valid !== 1'b1 || core.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overlap: rsp_valid=%b req_ready=%b, expected 1 1", core.rsp_valid, core.req_ready);
    end
    @(posedge clk); #1;
    core.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (core.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulse: rsp_valid=%b during load capture, expected 0", core.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (core.rsp_valid !== 1'b1 || core.rsp_rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL b2b_load: rsp_valid=%b rdata=%h, expected 1 0badf00d", core.rsp_valid, core.rsp_rdata);
    end
  endtask

  task automatic test_reset_mid_rmw();
    logic [31:0] d;
    logic        e;
    int          seen;
    do_req(1'b1, 3'b010, 32'h14, 32'h1234_5678, d, e);
    @(posedge clk); #1;
    core.req_valid  = 1'b1;
    core.req_we     = 1'b1;
    core.req_funct3 = 3'b001;
    core.req_addr   = 32'h16;
    core.req_wdata  = 32'h0000_CAFE;
    @(posedge clk); #1;
    core.req_valid = 1'b0;
    rst_n          = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || core.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmw_reset_we: mem_we=%b rsp_valid=%b, expected 0 0", mem_we, core.rsp_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (core.rsp_valid === 1'b1 || core.req_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rmw_reset_idle: %0d cycles with rsp_valid or not ready, expected 0", seen);
    end
    checks++;
    if (ram[5] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rmw_reset_ram: word5 got %h, expected 12345678", ram[5]);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic        e;
    logic [31:0] addr;
    for (int n = 0; n < 300; n++) begin
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(10, 31));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom, d, e);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    ram_clear       = 1'b1;
    core.req_valid  = 1'b0;
    core.req_we     = 1'b0;
    core.req_funct3 = 3'b000;
    core.req_addr   = '0;
    core.req_wdata  = '0;
    for (int i = 0; i < NBYTES; i++) ref_bytes[i] = 8'h00;
    test_reset();
    test_store_load();
    test_sub_word_store();
    test_load_extend();
    test_errors();
    test_bounds();
    test_back_to_back();
    test_reset_mid_rmw();
    check_ram("directed");
    test_random();
    check_ram("random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
